// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit.
interface logic_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             first;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             red_and;
    logic             red_or;
    logic             red_xor;
    logic             acc_busy;

    // Operand source and result consumer side
    modport master (
        output in_valid, a, b, op, acc_mode, first, last, out_ready,
        input  in_ready, out_valid, out, red_and, red_or, red_xor, acc_busy
    );

    // Logic unit side
    modport slave (
        input  in_valid, a, b, op, acc_mode, first, last, out_ready,
        output in_ready, out_valid, out, red_and, red_or, red_xor, acc_busy
    );
endinterface

// File: rtl/logic_unit.sv
// Registered WIDTH-bit bitwise logic unit with pairwise and framed-accumulate modes.
module logic_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_unit_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_ANDN  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    logic [0:0]       state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic             red_and_q,   red_and_d;
    logic             red_or_q,    red_or_d;
    logic             red_xor_q,   red_xor_d;

    logic             in_ready_c;
    logic             accept_c;
    logic             open_c;
    logic [WIDTH-1:0] res_c;

    // Selected bitwise function of two operands
    function automatic logic [WIDTH-1:0] f_op(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [2:0]       sel);
        logic [WIDTH-1:0] r;
        case (sel)
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_XOR:   r = x ^ y;
            OP_NAND:  r = ~(x & y);
            OP_NOR:   r = ~(x | y);
            OP_XNOR:  r = ~(x ^ y);
            OP_ANDN:  r = x & ~y;
            OP_PASSA: r = x;
            default:  r = x;
        endcase
        return r;
    endfunction

    // Only combinational output path: out_ready -> in_ready
    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next-state, accumulator fold and output register update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        red_and_d   = red_and_q;
        red_or_d    = red_or_q;
        red_xor_d   = red_xor_q;
        open_c      = bus.first || (state_q == IDLE);
        res_c       = f_op(bus.a, bus.b, bus.op);

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            if (!bus.acc_mode) begin
                // Pairwise beat emits directly and aborts any open frame
                state_d = IDLE;
            end else begin
                if (!open_c) begin
                    res_c = f_op(acc_q, bus.a, bus.op);
                end
                acc_d   = res_c;
                state_d = bus.last ? IDLE : ACCUM;
            end

            if (!bus.acc_mode || bus.last) begin
                out_d       = res_c;
                out_valid_d = 1'b1;
                red_and_d   = &res_c;
                red_or_d    = |res_c;
                red_xor_d   = ^res_c;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            red_and_q   <= 1'b0;
            red_or_q    <= 1'b0;
            red_xor_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            red_and_q   <= red_and_d;
            red_or_q    <= red_or_d;
            red_xor_q   <= red_xor_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.red_and   = red_and_q;
    assign bus.red_or    = red_or_q;
    assign bus.red_xor   = red_xor_q;
    assign bus.acc_busy  = (state_q == ACCUM);

endmodule
